attn_operand_fetch: RTL and testbench
=====================================

Name: attn_operand_fetch

Overview:
Upstream operand feeder for the self-attention matrix-multiply datapath. It reads the dimension headers and matrix elements from the input and weight SRAMs, and streams (A, B) operand pairs to the MAC stage in dot-product order with a valid/ready handshake. A 2-entry skid buffer absorbs the 1-cycle SRAM read latency so the consumer can apply backpressure.

Parameters:
ADDR_W, 16, SRAM address width.
DATA_W, 32, SRAM data and operand width.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request to begin a fetch job; ignored while busy=1.
busy  out  1  high from the cycle after start is accepted until the cycle done pulses.
done  out  1  one-cycle pulse when the job completes.
input_read_address  out  ADDR_W  input SRAM (matrix A) read address.
input_read_data  in  DATA_W  input SRAM data; valid the cycle after its address.
weight_read_address  out  ADDR_W  weight SRAM (matrix B) read address.
weight_read_data  in  DATA_W  weight SRAM data; valid the cycle after its address.
dim_m  out  16  A rows, latched from input word 0 [31:16].
dim_k  out  16  A cols / B rows, latched from input word 0 [15:0].
dim_n  out  16  B cols, latched from weight word 0 [15:0].
op_valid  out  1  operand pair available.
op_ready  in  1  consumer accepts the pair when op_valid&&op_ready.
op_a  out  DATA_W  element A[r][k].
op_b  out  DATA_W  element B[k][c].
op_last  out  1  pair is k=dim_k-1; the dot product for (r,c) is complete.
op_row  out  16  r of the current pair.
op_col  out  16  c of the current pair.

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, op_valid, op_last = 0; dims, op_a, op_b, op_row, op_col = 0; both addresses = 0; FIFO emptied; in-flight read discarded.
- Memory layout: A is row-major at input address 1 + r*K + k. B is column-major at weight address 1 + c*K + k. Word 0 of each SRAM is the header. Address arithmetic is modulo 2^ADDR_W. Callers guarantee M*K and N*K are < 2^ADDR_W.
- Iteration order: r outer (0..M-1), c middle (0..N-1), k inner (0..K-1). The job emits exactly M*N*K pairs.
- States:
  - IDLE: addresses driven 0. When start=1, go to HDR.
  - HDR: busy=1; capture dim_m, dim_k, dim_n from the read data. If any dimension is 0, go to FIN. Otherwise clear r, c, k and go to STREAM.
  - STREAM: issue one address pair in a cycle only if (fifo_count + inflight - pop) < 2, where pop = op_valid&&op_ready. Advance k, then c, then r. After the pair with r=M-1, c=N-1, k=K-1 is issued, go to DRAIN.
  - DRAIN: stop issuing; addresses hold their last value. When the FIFO is empty, no read is in flight, and the final pair has handshaken, go to FIN.
  - FIN: done=1 for one cycle, busy=0; return to IDLE.
- Skid FIFO: 2 entries. Each entry holds {a, b, last, row, col}; the row/col/last tags travel with the issued read. The head of the FIFO drives the op_* outputs. Push and pop in the same cycle are legal. The FIFO never overflows, by the credit rule above.
- Timing: start sampled at cycle 0 → HDR at cycle 1 → first issue at cycle 2 → first op_valid at cycle 4. With op_ready held at 1, pairs handshake one per cycle, with no bubbles. done pulses 1 cycle after the final handshake.
- op_valid stays asserted and op_* stay stable while op_ready=0.
- Dimension outputs hold their value after done until the next job's HDR cycle.

Test Plan:
- M=2,K=2,N=2, A=[1,2;3,4], B columns [5,7],[6,8], op_ready=1 → pairs (1,5)(2,7)(1,6)(2,8)(3,5)(4,7)(3,6)(4,8); op_last on every 2nd pair; first op_valid at cycle 4; done at cycle 12.
- Same job with op_ready toggling in a 1-on/2-off pattern → identical pair sequence; outputs stable while stalled; no pair dropped or duplicated; FIFO count never exceeds 2.
- M=1,K=1,N=1, A=9, B=3 → single pair (9,3) with op_last=1, row=0, col=0; done 1 cycle after the handshake.
- Header with K=0 (M=3,N=3) → no op_valid ever; done pulses at cycle 2; dim_k=0.
- start re-pulsed mid-job → ignored; pair count stays M*N*K. Back-to-back job started the cycle after done → dims re-latched and the stream restarts at r=c=k=0.
- reset asserted mid-STREAM with op_valid=1 → op_valid, busy, done drop to 0 immediately (async); a fresh start after deassertion yields the full correct sequence.

Source files
------------

// File: rtl/attn_operand_fetch.sv
// Operand fetch front-end for the attention matmul datapath.
// Reads the dimension headers, then walks A (row-major) and B (column-major)
// in r/c/k order and streams (A,B) pairs through a 2-entry skid FIFO that
// hides the 1-cycle SRAM read latency from a back-pressuring consumer.
module attn_operand_fetch #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] input_read_address,
   input  logic [DATA_W-1:0] input_read_data,
   output logic [ADDR_W-1:0] weight_read_address,
   input  logic [DATA_W-1:0] weight_read_data,
   output logic [15:0]       dim_m,
   output logic [15:0]       dim_k,
   output logic [15:0]       dim_n,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   output logic              op_last,
   output logic [15:0]       op_row,
   output logic [15:0]       op_col
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_HDR    = 3'd1;
   localparam logic [2:0] S_STREAM = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_FIN    = 3'd4;

   logic [2:0] state;

   // loop indices and running base addresses (1 + r*K and 1 + c*K)
   logic [15:0]       r_idx, c_idx, k_idx;
   logic [ADDR_W-1:0] a_base, b_base;
   logic [ADDR_W-1:0] a_hold, b_hold;
   logic [ADDR_W-1:0] a_issue, b_issue, k_step;

   // tags of the read currently in flight in the SRAM
   logic        inflight;
   logic [15:0] tag_row, tag_col;
   logic        tag_last;

   // skid FIFO storage
   logic [1:0][DATA_W-1:0] f_a, f_b;
   logic [1:0][15:0]       f_row, f_col;
   logic [1:0]             f_last;
   logic                   wr_ptr, rd_ptr;
   logic [1:0]             count, count_next;

   logic       push, pop, issue;
   logic       k_last, c_last, r_last;
   logic [2:0] occupancy;

   assign push = inflight;
   assign pop  = op_valid & op_ready;

   // a slot is committed as soon as its read is issued, so credits count
   // both stored entries and the read still in the SRAM pipe
   assign occupancy  = 3'(count) + 3'(inflight) - 3'(pop);
   assign issue      = (state == S_STREAM) && (occupancy < 3'd2);
   assign count_next = count + 2'(push) - 2'(pop);

   assign k_last = (k_idx == dim_k - 16'd1);
   assign c_last = (c_idx == dim_n - 16'd1);
   assign r_last = (r_idx == dim_m - 16'd1);

   assign k_step  = ADDR_W'(dim_k);
   assign a_issue = a_base + ADDR_W'(k_idx);
   assign b_issue = b_base + ADDR_W'(k_idx);

   // addresses: header word while idle, fresh address on issue, else hold
   always_comb begin
      input_read_address  = a_hold;
      weight_read_address = b_hold;
      if (state == S_IDLE) begin
         input_read_address  = '0;
         weight_read_address = '0;
      end else if (issue) begin
         input_read_address  = a_issue;
         weight_read_address = b_issue;
      end
   end

   assign busy = (state == S_HDR) || (state == S_STREAM) || (state == S_DRAIN);
   assign done = (state == S_FIN);

   // control FSM, header capture and r/c/k walk
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         dim_m  <= '0;
         dim_k  <= '0;
         dim_n  <= '0;
         r_idx  <= '0;
         c_idx  <= '0;
         k_idx  <= '0;
         a_base <= '0;
         b_base <= '0;
         a_hold <= '0;
         b_hold <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               a_hold <= '0;
               b_hold <= '0;
               if (start) state <= S_HDR;
            end
            S_HDR: begin
               dim_m <= input_read_data[31:16];
               dim_k <= input_read_data[15:0];
               dim_n <= weight_read_data[15:0];
               r_idx  <= '0;
               c_idx  <= '0;
               k_idx  <= '0;
               a_base <= ADDR_W'(1);
               b_base <= ADDR_W'(1);
               if ((input_read_data[31:16] == 16'd0) ||
                   (input_read_data[15:0] == 16'd0) ||
                   (weight_read_data[15:0] == 16'd0))
                  state <= S_FIN;
               else
                  state <= S_STREAM;
            end
            S_STREAM: begin
               if (issue) begin
                  a_hold <= a_issue;
                  b_hold <= b_issue;
                  if (k_last) begin
                     k_idx <= '0;
                     if (c_last) begin
                        c_idx  <= '0;
                        b_base <= ADDR_W'(1);
                        r_idx  <= r_idx + 16'd1;
                        a_base <= a_base + k_step;
                     end else begin
                        c_idx  <= c_idx + 16'd1;
                        b_base <= b_base + k_step;
                     end
                  end else begin
                     k_idx <= k_idx + 16'd1;
                  end
                  if (k_last && c_last && r_last) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if ((count_next == 2'd0) && !inflight) state <= S_FIN;
            end
            S_FIN: begin
               a_hold <= '0;
               b_hold <= '0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // tags ride alongside the read so they meet their data one cycle later
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight <= 1'b0;
         tag_row  <= '0;
         tag_col  <= '0;
         tag_last <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            tag_row  <= r_idx;
            tag_col  <= c_idx;
            tag_last <= k_last;
         end
      end
   end

   // skid FIFO: push returning read data, pop on handshake
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         f_a    <= '0;
         f_b    <= '0;
         f_row  <= '0;
         f_col  <= '0;
         f_last <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push) begin
            f_a[wr_ptr]    <= input_read_data;
            f_b[wr_ptr]    <= weight_read_data;
            f_row[wr_ptr]  <= tag_row;
            f_col[wr_ptr]  <= tag_col;
            f_last[wr_ptr] <= tag_last;
            wr_ptr         <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count_next;
      end
   end

   assign op_valid = (count != 2'd0);
   assign op_a     = f_a[rd_ptr];
   assign op_b     = f_b[rd_ptr];
   assign op_row   = f_row[rd_ptr];
   assign op_col   = f_col[rd_ptr];
   assign op_last  = f_last[rd_ptr];

endmodule

// File: tb/tb_attn_operand_fetch.sv
// Directed bench for attn_operand_fetch: SRAM models, a queue-based model of
// the r/c/k pair stream, and a negedge compare process.
module tb_attn_operand_fetch;
   localparam int AW = 16;
   localparam int DW = 32;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        last;
      logic [15:0] row;
      logic [15:0] col;
   } pair_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          busy, done;
   logic [AW-1:0] input_read_address, weight_read_address;
   logic [DW-1:0] input_read_data, weight_read_data;
   logic [15:0]   dim_m, dim_k, dim_n;
   logic          op_valid;
   logic          op_ready = 1'b0;
   logic [DW-1:0] op_a, op_b;
   logic          op_last;
   logic [15:0]   op_row, op_col;

   attn_operand_fetch #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .input_read_address(input_read_address), .input_read_data(input_read_data),
      .weight_read_address(weight_read_address), .weight_read_data(weight_read_data),
      .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
      .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
      .op_last(op_last), .op_row(op_row), .op_col(op_col));

   always #5 clk = ~clk;

   // SRAM models: data valid the cycle after the address
   logic [31:0] imem [0:255];
   logic [31:0] wmem [0:255];
   always @(posedge clk) begin
      input_read_data  <= imem[input_read_address[7:0]];
      weight_read_data <= wmem[weight_read_address[7:0]];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // consumer: 0 = stalled, 1 = always ready, 2 = ready one cycle in three
   int rmode = 1;
   always @(posedge clk) begin
      #1;
      case (rmode)
         0: op_ready = 1'b0;
         1: op_ready = 1'b1;
         default: op_ready = (cyc % 3 == 0);
      endcase
   end

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // matrices: A[r][k], B[k][c]
   logic [31:0] A [0:7][0:7];
   logic [31:0] B [0:7][0:7];
   pair_t       exp_q[$];

   // literal pins for the test-plan jobs
   logic [31:0] lit_a [0:7];
   logic [31:0] lit_b [0:7];
   logic        lit_last [0:7];
   int          lit_n = 0;
   int          lit_idx = 0;

   int  pairs = 0;
   int  start_cyc = 0;
   int  done_cyc = 0;
   int  first_valid_cyc = 0;
   bit  done_seen = 0;
   bit  first_valid_seen = 0;
   bit  prev_stall = 0;
   pair_t prev_pair;

   // compare process
   always @(negedge clk) begin
      pair_t cur, e;
      cur = {op_a, op_b, op_last, op_row, op_col};
      if (reset) begin
         prev_stall = 0;
      end else begin
         if (prev_stall) chk("stall_hold", {op_valid, cur}, {1'b1, prev_pair});
         if (op_valid && !first_valid_seen) begin
            first_valid_seen = 1;
            first_valid_cyc  = cyc;
         end
         if (done) begin
            done_seen = 1;
            done_cyc  = cyc;
         end
         if (op_valid && op_ready) begin
            if (exp_q.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL extra_pair: got %0h expected none", cur);
            end else begin
               e = exp_q.pop_front();
               chk("pair", cur, e);
               if (lit_idx < lit_n)
                  chk("pair_lit", {op_a, op_b, op_last},
                      {lit_a[lit_idx], lit_b[lit_idx], lit_last[lit_idx]});
               lit_idx++;
            end
            pairs++;
         end
         prev_stall = op_valid && !op_ready;
         prev_pair  = cur;
      end
   end

   task automatic load_job(input int M, input int K, input int N);
      for (int i = 0; i < 256; i++) begin
         imem[i] = 32'hDEAD0000 + i;
         wmem[i] = 32'hBEEF0000 + i;
      end
      imem[0] = {M[15:0], K[15:0]};
      wmem[0] = {16'hABCD, N[15:0]};
      for (int r = 0; r < M; r++)
         for (int k = 0; k < K; k++) imem[1 + r*K + k] = A[r][k];
      for (int c = 0; c < N; c++)
         for (int k = 0; k < K; k++) wmem[1 + c*K + k] = B[k][c];
      exp_q.delete();
      for (int r = 0; r < M; r++)
         for (int c = 0; c < N; c++)
            for (int k = 0; k < K; k++)
               exp_q.push_back({A[r][k], B[k][c], (k == K-1), 16'(r), 16'(c)});
   endtask

   // called just after a posedge; start is driven in the current cycle
   task automatic run_job(input int M, input int K, input int N, input int mode, input bit repulse);
      load_job(M, K, N);
      pairs = 0;
      lit_idx = 0;
      done_seen = 0;
      first_valid_seen = 0;
      rmode = mode;
      start = 1'b1;
      start_cyc = cyc;
      for (int n = 1; n <= 400 && !done_seen; n++) begin
         @(posedge clk);
         #1;
         start = (repulse && n == 5);
      end
      start = 1'b0;
      chk("done_seen", done_seen, 1);
      chk("pair_count", pairs, M*N*K);
      chk("exp_left", exp_q.size(), 0);
      chk("dims", {dim_m, dim_k, dim_n}, {M[15:0], K[15:0], N[15:0]});
      if (M*N*K == 0) begin
         chk("no_valid", first_valid_seen, 0);
         chk("done_cyc_empty", done_cyc - start_cyc, 2);
      end else if (mode == 1) begin
         chk("first_valid_cyc", first_valid_cyc - start_cyc, 4);
         chk("done_cyc", done_cyc - start_cyc, 4 + M*N*K);
      end
   endtask

   task automatic set_tp222();
      A[0][0] = 1; A[0][1] = 2; A[1][0] = 3; A[1][1] = 4;
      B[0][0] = 5; B[1][0] = 7; B[0][1] = 6; B[1][1] = 8;
      lit_a = '{1, 2, 1, 2, 3, 4, 3, 4};
      lit_b = '{5, 7, 6, 8, 5, 7, 6, 8};
      lit_last = '{0, 1, 0, 1, 0, 1, 0, 1};
      lit_n = 8;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         imem[i] = '0;
         wmem[i] = '0;
      end
      #1 reset = 1'b1;
      #2;
      chk("rst_outputs", {busy, done, op_valid, op_last},  4'b0);
      chk("rst_dims", {dim_m, dim_k, dim_n}, 48'd0);
      chk("rst_addr", {input_read_address, weight_read_address}, 32'd0);
      chk("rst_ops", {op_a, op_b, op_row, op_col}, 96'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;

      // test-plan 2x2x2, full rate
      set_tp222();
      run_job(2, 2, 2, 1, 0);
      chk("tp_done12", done_cyc - start_cyc, 12);
      chk("tp_first4", first_valid_cyc - start_cyc, 4);
      @(posedge clk); #1;

      // same job with 1-on/2-off backpressure
      run_job(2, 2, 2, 2, 0);
      @(posedge clk); #1;

      // 1x1x1
      A[0][0] = 9; B[0][0] = 3;
      lit_a[0] = 9; lit_b[0] = 3; lit_last[0] = 1; lit_n = 1;
      run_job(1, 1, 1, 1, 0);
      chk("tp_single_done", done_cyc - start_cyc, 5);
      lit_n = 0;
      @(posedge clk); #1;

      // K = 0 header
      run_job(3, 0, 3, 1, 0);
      chk("tp_k0_dimk", dim_k, 0);
      @(posedge clk); #1;

      // 2x3x3 with a mid-job start pulse, then an immediate back-to-back job
      for (int r = 0; r < 8; r++)
         for (int k = 0; k < 8; k++) begin
            A[r][k] = 32'h100 + r*16 + k;
            B[k][r] = 32'h200 + k*16 + r;
         end
      run_job(2, 3, 3, 1, 1);
      for (int r = 0; r < 8; r++)
         for (int k = 0; k < 8; k++) begin
            A[r][k] = r*7 + k*3 + 1;
            B[k][r] = 50 + r*5 + k;
         end
      run_job(3, 2, 2, 2, 0);
      @(posedge clk); #1;

      // reset while a pair is stalled at the output
      set_tp222();
      lit_n = 0;
      load_job(2, 2, 2);
      rmode = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 0; n < 20 && !op_valid; n++) begin
         @(posedge clk); #1;
      end
      chk("rst_pre_valid", op_valid, 1);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rst_async", {op_valid, busy, done}, 3'b000);
      chk("rst_async_dims", {dim_m, dim_k, dim_n}, 48'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      set_tp222();
      run_job(2, 2, 2, 1, 0);
      chk("post_rst_done12", done_cyc - start_cyc, 12);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
